// File: rtl/ef_smsdac_ctrl.sv
// ef_smsdac_ctrl: sample scheduler and start/stop sequencer for the segmented
// mismatch-shaping DAC core. Buffers 8-bit samples in a small FIFO, holds each
// one on d_in for osr+1 clocks, and starts/stops the encoder at mid-scale.
// Optional feature macro: EF_SMSDAC_CTRL_UFCNT_EN adds an 8-bit saturating
// underflow counter output (uf_cnt).
module ef_smsdac_ctrl #(
    parameter int unsigned OSR_W      = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned SETTLE_CYC = 16,
    parameter logic [7:0]  MID        = 8'h80
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             dith_cfg,
    input  logic [OSR_W-1:0] osr,
    input  logic             mute,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [7:0]       s_data,
    output logic [7:0]       d_in,
    output logic             en_enc,
    output logic             en_dith,
    output logic             busy,
    output logic             uf,
    input  logic             clr_uf
`ifdef EF_SMSDAC_CTRL_UFCNT_EN
    ,
    output logic [7:0]       uf_cnt
`endif
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned OCC_W = PTR_W + 1;
    localparam int unsigned SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int unsigned CNT_W = (OSR_W > SET_W) ? OSR_W : SET_W;
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);
    localparam logic [OCC_W-1:0] OCC_FULL    = OCC_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETTLE = 3'd1,
        ARM    = 3'd2,
        RUN    = 3'd3,
        DRAIN  = 3'd4
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [7:0]         mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [OCC_W-1:0]   occ;

    logic               empty_c;
    logic               boundary_c;
    logic               pop_c;
    logic               push_c;
    logic               uf_evt_c;
    logic               flush_c;
    logic               active_nxt_c;
    logic [OCC_W-1:0]   occ_nxt_c;

    // Hold-boundary, FIFO handshake and flush decisions for this cycle.
    always_comb begin
        empty_c      = (occ == '0);
        boundary_c   = (state == RUN) && (cnt == '0);
        pop_c        = boundary_c && start && !empty_c;
        uf_evt_c     = boundary_c && start && empty_c;
        push_c       = s_valid && s_ready;
        flush_c      = (state == IDLE)
                     || (((state == SETTLE) || (state == ARM)) && !start)
                     || ((state == DRAIN) && (cnt == '0));
        active_nxt_c = (((state == IDLE) || (state == SETTLE) || (state == ARM)) && start)
                     || ((state == RUN) && !(boundary_c && !start));
        occ_nxt_c    = flush_c ? '0 : (occ + OCC_W'(push_c) - OCC_W'(pop_c));
    end

    // Sample storage; contents are meaningless once pointers are flushed.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= s_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap modulo the depth.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            occ <= occ_nxt_c;
            if (flush_c) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // Sequencer: state, shared settle/hold counter and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            d_in    <= MID;
            en_enc  <= 1'b0;
            en_dith <= 1'b0;
            s_ready <= 1'b0;
            busy    <= 1'b0;
        end else begin
            s_ready <= active_nxt_c && (occ_nxt_c != OCC_FULL);
            case (state)
                IDLE: begin
                    d_in    <= MID;
                    en_enc  <= 1'b0;
                    en_dith <= 1'b0;
                    busy    <= start;
                    if (start) begin
                        state <= SETTLE;
                        cnt   <= SETTLE_LOAD;
                    end
                end
                SETTLE: begin
                    d_in <= MID;
                    if (!start) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (cnt == '0) begin
                        state   <= ARM;
                        en_enc  <= 1'b1;
                        en_dith <= dith_cfg;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ARM: begin
                    d_in <= MID;
                    if (!start) begin
                        state   <= IDLE;
                        en_enc  <= 1'b0;
                        en_dith <= 1'b0;
                        busy    <= 1'b0;
                    end else begin
                        state <= RUN;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    if (cnt == '0) begin
                        if (!start) begin
                            state <= DRAIN;
                            cnt   <= SETTLE_LOAD;
                            d_in  <= MID;
                        end else begin
                            cnt <= CNT_W'(osr);
                            if (pop_c) d_in <= mute ? MID : mem[rd_ptr];
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                DRAIN: begin
                    d_in <= MID;
                    if (cnt == '0) begin
                        state   <= IDLE;
                        en_enc  <= 1'b0;
                        en_dith <= 1'b0;
                        busy    <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    d_in    <= MID;
                    en_enc  <= 1'b0;
                    en_dith <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    // Sticky underflow flag; a new underflow beats a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            uf <= 1'b0;
        end else if (uf_evt_c) begin
            uf <= 1'b1;
        end else if (clr_uf) begin
            uf <= 1'b0;
        end
    end

`ifdef EF_SMSDAC_CTRL_UFCNT_EN
    // Saturating underflow counter; an increment beats a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            uf_cnt <= 8'h00;
        end else if (uf_evt_c) begin
            if (uf_cnt != 8'hFF) uf_cnt <= uf_cnt + 8'd1;
        end else if (clr_uf) begin
            uf_cnt <= 8'h00;
        end
    end
`endif

endmodule
